// File: rtl/pool_quant_pkg.sv
// rtl/pool_quant_pkg.sv - shared constants, state type and rounding helper for pool_quant
package pool_quant_pkg;

    localparam int DW       = 24;
    localparam int IN_H     = 12;
    localparam int IN_W     = 11;
    localparam int P_H      = IN_H / 2;
    localparam int P_W      = IN_W / 2;
    localparam int INT8_MAX = 127;
    localparam int CHAN_W   = 4;
    localparam int SHIFT_W  = 5;
    localparam int ROW_W    = 3;
    localparam int COL_W    = 3;
    localparam int RIDX_W   = $clog2(IN_H);
    localparam int CIDX_W   = $clog2(IN_W);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Half-up bias for a right shift by sh; zero when no shift.
    function automatic logic [DW:0] round_bias(input logic [SHIFT_W-1:0] sh);
        if (sh == '0)
            return '0;
        return (DW+1)'(1) << (sh - 1'b1);
    endfunction

endpackage

// File: rtl/pool_quant_if.sv
// rtl/pool_quant_if.sv - map input and pooled-pixel stream bundle for pool_quant
interface pool_quant_if;
    import pool_quant_pkg::*;

    logic signed [DW-1:0]     in_map [0:IN_H-1][0:IN_W-1];
    logic                     in_valid;
    logic [CHAN_W-1:0]        in_chan;
    logic [SHIFT_W-1:0]       quant_shift;

    logic signed [7:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [CHAN_W-1:0]        out_chan;
    logic [ROW_W-1:0]         out_row;
    logic [COL_W-1:0]         out_col;
    logic                     out_last;

    modport master (
        output in_map, in_valid, in_chan, quant_shift, out_ready,
        input  out_data, out_valid, out_chan, out_row, out_col, out_last
    );

    modport slave (
        input  in_map, in_valid, in_chan, quant_shift, out_ready,
        output out_data, out_valid, out_chan, out_row, out_col, out_last
    );

endinterface

// File: rtl/pool_quant_unit.sv
// rtl/pool_quant_unit.sv - 4-way signed max, ReLU, shift requant (POOL_QUANT_ROUND_EN adds half-up rounding), INT8 saturate
module pool_quant_unit
    import pool_quant_pkg::*;
(
    input  logic signed [DW-1:0]  s0,
    input  logic signed [DW-1:0]  s1,
    input  logic signed [DW-1:0]  s2,
    input  logic signed [DW-1:0]  s3,
    input  logic [SHIFT_W-1:0]    shift,
    output logic [7:0]            pix
);

    logic signed [DW-1:0] m01;
    logic signed [DW-1:0] m23;
    logic signed [DW-1:0] m;
    logic [DW:0]          r;
    logic [DW:0]          rnd;
    logic [DW:0]          q;

    always_comb begin
        m01 = (s0 > s1) ? s0 : s1;
        m23 = (s2 > s3) ? s2 : s3;
        m   = (m01 > m23) ? m01 : m23;
        r   = m[DW-1] ? '0 : {1'b0, m};
`ifdef POOL_QUANT_ROUND_EN
        rnd = round_bias(shift);
`else
        rnd = '0;
`endif
        // r is non-negative after ReLU, so a logical shift matches >>>.
        q   = (r + rnd) >> shift;
        pix = (q > (DW+1)'(INT8_MAX)) ? 8'(INT8_MAX) : q[7:0];
    end

endmodule

// File: rtl/pool_quant.sv
// rtl/pool_quant.sv - map capture, window FSM and output register for 2x2 max-pool + INT8 requant (option: POOL_QUANT_ROUND_EN)
module pool_quant
    import pool_quant_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    pool_quant_if.slave     bus,
    output logic            busy,
    output logic            drop_err
);

    state_t state_q, state_d;

    logic                   in_valid_q;
    logic                   start, last_hs, accept, bypass, advance, pend, win_last;
    logic signed [DW-1:0]   cap_map [0:IN_H-1][0:IN_W-1];
    logic [CHAN_W-1:0]      chan_q;
    logic [SHIFT_W-1:0]     shift_q;
    logic [ROW_W-1:0]       pr;
    logic [COL_W-1:0]       pc;
    logic [RIDX_W-1:0]      r0, r1;
    logic [CIDX_W-1:0]      c0, c1;
    logic signed [DW-1:0]   w0, w1, w2, w3;
    logic [SHIFT_W-1:0]     win_shift;
    logic [7:0]             pix;

    logic [7:0]             out_data_q;
    logic                   out_valid_q, out_last_q;
    logic [CHAN_W-1:0]      out_chan_q;
    logic [ROW_W-1:0]       out_row_q;
    logic [COL_W-1:0]       out_col_q;

    assign start    = bus.in_valid & ~in_valid_q;
    assign last_hs  = out_valid_q & bus.out_ready & out_last_q;
    assign accept   = start & ((state_q == ST_IDLE) | ((state_q == ST_RUN) & last_hs));
    // A map accepted on the last handshake feeds window (0,0) straight from in_map,
    // so consecutive channels stream without a gap.
    assign bypass   = accept & (state_q == ST_RUN);
    assign advance  = ~out_valid_q | bus.out_ready;
    assign win_last = (pr == ROW_W'(P_H-1)) & (pc == COL_W'(P_W-1));
    assign busy     = (state_q == ST_RUN);

    assign r0 = RIDX_W'({pr, 1'b0});
    assign r1 = RIDX_W'({pr, 1'b1});
    assign c0 = CIDX_W'({pc, 1'b0});
    assign c1 = CIDX_W'({pc, 1'b1});

    always_comb begin
        w0        = cap_map[r0][c0];
        w1        = cap_map[r0][c1];
        w2        = cap_map[r1][c0];
        w3        = cap_map[r1][c1];
        win_shift = shift_q;
        if (bypass) begin
            w0        = bus.in_map[0][0];
            w1        = bus.in_map[0][1];
            w2        = bus.in_map[1][0];
            w3        = bus.in_map[1][1];
            win_shift = bus.quant_shift;
        end
    end

    pool_quant_unit u_unit (
        .s0    (w0),
        .s1    (w1),
        .s2    (w2),
        .s3    (w3),
        .shift (win_shift),
        .pix   (pix)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last_hs && !start) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IN_H; i++)
                for (int j = 0; j < IN_W; j++)
                    cap_map[i][j] <= '0;
            chan_q  <= '0;
            shift_q <= '0;
        end else if (accept) begin
            cap_map <= bus.in_map;
            chan_q  <= bus.in_chan;
            shift_q <= bus.quant_shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_valid_q  <= 1'b0;
            drop_err    <= 1'b0;
            pr          <= '0;
            pc          <= '0;
            pend        <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_chan_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            in_valid_q <= bus.in_valid;
            if (start && !accept)
                drop_err <= 1'b1;

            if (advance) begin
                if (bypass) begin
                    out_data_q  <= pix;
                    out_valid_q <= 1'b1;
                    out_chan_q  <= bus.in_chan;
                    out_row_q   <= '0;
                    out_col_q   <= '0;
                    out_last_q  <= 1'b0;
                    pr          <= '0;
                    pc          <= COL_W'(1);
                    pend        <= 1'b1;
                end else if (pend) begin
                    out_data_q  <= pix;
                    out_valid_q <= 1'b1;
                    out_chan_q  <= chan_q;
                    out_row_q   <= pr;
                    out_col_q   <= pc;
                    out_last_q  <= win_last;
                    pend        <= ~win_last;
                    if (pc == COL_W'(P_W-1)) begin
                        pc <= '0;
                        pr <= pr + 1'b1;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end else begin
                    out_valid_q <= 1'b0;
                end
            end

            if (accept && !bypass) begin
                pr   <= '0;
                pc   <= '0;
                pend <= 1'b1;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_pool_quant.sv
// tb/tb_pool_quant.sv - self-checking bench for pool_quant (honours POOL_QUANT_ROUND_EN)
module tb_pool_quant;
    import pool_quant_pkg::*;

    typedef struct {
        int data;
        int row;
        int col;
        int chan;
        int last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, drop_err;

    pool_quant_if bus();

    pool_quant dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         mp [IN_H][IN_W];
    beat_t      exp_q [$];
    logic [7:0] got_data [64];
    int         cur_chan = 0;
    int         rng = 1 << 16;

    function automatic int ref_pix(int r, int c, int sh);
        int     m;
        longint t;
        m = mp[2*r][2*c];
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                if (mp[2*r+dr][2*c+dc] > m)
                    m = mp[2*r+dr][2*c+dc];
        if (m < 0)
            m = 0;
        t = m;
`ifdef POOL_QUANT_ROUND_EN
        if (sh > 0)
            t = t + (longint'(1) << (sh - 1));
`endif
        t = t >>> sh;
        return (t > 127) ? 127 : int'(t);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_zero();
        for (int i = 0; i < IN_H; i++)
            for (int j = 0; j < IN_W; j++)
                mp[i][j] = 0;
    endtask

    task automatic fill_rand(input int lim);
        for (int i = 0; i < IN_H; i++)
            for (int j = 0; j < IN_W; j++)
                mp[i][j] = int'($urandom_range(0, 2 * lim)) - lim;
    endtask

    task automatic drive_map(input int ch, input int sh, input bit model);
        for (int i = 0; i < IN_H; i++)
            for (int j = 0; j < IN_W; j++)
                bus.in_map[i][j] = DW'(mp[i][j]);
        bus.in_chan     = CHAN_W'(ch);
        bus.quant_shift = SHIFT_W'(sh);
        if (model)
            for (int r = 0; r < P_H; r++)
                for (int c = 0; c < P_W; c++)
                    exp_q.push_back('{ref_pix(r, c, sh), r, c, ch,
                                      int'(r == P_H-1 && c == P_W-1)});
    endtask

    task automatic start_chan(input int ch, input int sh);
        cur_chan = ch;
        drive_map(ch, sh, 1'b1);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Consumes n beats; mode 1 toggles ready and stalls 5 cycles; optionally launches
    // further channels on each last beat or raises a stray start after intrude_at beats.
    task automatic stream(input int n, input int mode, input int launch_cnt,
                          input int intrude_at, input int sh);
        int          got = 0;
        int          cyc = 0;
        int          launches = 0;
        bit          stalled = 1'b0;
        bit          chk_nb = 1'b0;
        bit          rdy;
        logic [31:0] obs, held, ob, eb;
        beat_t       e;
        while (got < n && cyc < 400) begin
            bus.in_valid = 1'b0;
            rdy = (mode == 0) ? 1'b1 : ((cyc >= 12 && cyc < 17) ? 1'b0 : (cyc % 2 == 0));
            bus.out_ready = rdy;
            obs = {12'b0, bus.out_valid, bus.out_data, bus.out_row, bus.out_col,
                   bus.out_chan, bus.out_last};
            if (chk_nb)
                check("no_bubble", 32'(bus.out_valid), 32'd1);
            chk_nb = 1'b0;
            if (stalled)
                check("stall_hold", obs, held);
            stalled = bus.out_valid && !rdy;
            held = obs;
            if (bus.out_valid && rdy) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '{-1, 7, 7, 15, 0};
                ob = {13'b0, bus.out_data, bus.out_row, bus.out_col, bus.out_chan, bus.out_last};
                eb = {13'b0, 8'(e.data), 3'(e.row), 3'(e.col), 4'(e.chan), 1'(e.last)};
                check("beat", ob, eb);
                if (got < 64)
                    got_data[got] = bus.out_data;
                if (bus.out_last && launches < launch_cnt) begin
                    launches++;
                    cur_chan++;
                    fill_rand(rng);
                    drive_map(cur_chan, sh, 1'b1);
                    bus.in_valid = 1'b1;
                    chk_nb = 1'b1;
                end
                got++;
                if (intrude_at > 0 && got == intrude_at) begin
                    fill_rand(rng);
                    drive_map(9, sh, 1'b0);
                    bus.in_valid = 1'b1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("beat_count", 32'(got), 32'(n));
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.in_chan     = '0;
        bus.quant_shift = '0;
        fill_zero();
        drive_map(0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_err), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_last", 32'(bus.out_last), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: single hot pixel, latency and 30-beat frame
        fill_zero();
        mp[0][0] = 1000;
        start_chan(0, 3);
        check("t1_lat_edge", 32'(bus.out_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("t1_lat_next", 32'(bus.out_valid), 32'd1);
        stream(30, 0, 0, 0, 3);
        check("t1_pix00", 32'(got_data[0]), 32'd125);
        check("t1_end_valid", 32'(bus.out_valid), 32'd0);
        check("t1_end_busy", 32'(busy), 32'd0);

        // T2: negative window, saturation, dropped column 10, ReLU+shift
        fill_zero();
        mp[0][0] = -5;  mp[0][1] = -9; mp[1][0] = -1; mp[1][1] = -7;
        mp[0][2] = 300; mp[0][3] = 2;  mp[1][2] = 3;  mp[1][3] = 4;
        for (int i = 0; i < IN_H; i++)
            mp[i][10] = 8000000;
        start_chan(1, 0);
        stream(30, 0, 0, 0, 0);
        check("t2_neg", 32'(got_data[0]), 32'd0);
        check("t2_sat", 32'(got_data[1]), 32'd127);
        fill_zero();
        mp[0][0] = -100; mp[0][1] = 20; mp[1][0] = 5; mp[1][1] = 19;
        start_chan(2, 2);
        stream(30, 0, 0, 0, 2);
        check("t2_shift2", 32'(got_data[0]), 32'd5);

        // T3: backpressure
        fill_rand(1 << 16);
        start_chan(3, 12);
        stream(30, 1, 0, 0, 12);

        // T4: back-to-back channel, then a stray start mid-map
        rng = 1 << 20;
        fill_rand(rng);
        start_chan(4, 9);
        stream(30, 0, 1, 0, 9);
        check("t4_no_bubble", 32'(bus.out_valid), 32'd1);
        check("t4_drop_clear", 32'(drop_err), 32'd0);
        stream(30, 0, 0, 10, 9);
        check("t4_drop_set", 32'(drop_err), 32'd1);
        check("t4_end_busy", 32'(busy), 32'd0);

        // T5: async reset mid-channel
        fill_rand(rng);
        start_chan(6, 5);
        stream(12, 0, 0, 0, 5);
        rst = 1'b1;
        #1;
        check("t5_valid", 32'(bus.out_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_drop", 32'(drop_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        fill_rand(rng);
        start_chan(7, 5);
        stream(30, 0, 0, 0, 5);

        // T6: four random channels streamed back to back
        rng = 1 << 19;
        fill_rand(rng);
        start_chan(0, 10);
        stream(120, 0, 3, 0, 10);
        check("t6_end_valid", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
